// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer that time-shares one Multiplicador between two requesters.
// Drives the clear/start sequence, times completion by counter and returns the product.
module mul_share_ctrl #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned MUL_LAT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic        req1,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        res_neg,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_rst,
  output logic        mul_start,
  input  logic [15:0] mul_c,
  input  logic        mul_neg
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD   = CNT_W'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SETUP = 3'd2,
    S_RUN   = 3'd3,
    S_CAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic [OP_W-1:0]    mul_a_q, mul_a_d;
  logic [OP_W-1:0]    mul_b_q, mul_b_d;
  logic               mul_rst_q, mul_rst_d;
  logic               mul_start_q, mul_start_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               res_neg_q, res_neg_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               grant_id;

  // Next-state and next-output logic; every output is the registered image of its _d.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_d       = res_q;
    res_neg_d   = res_neg_q;
    mul_rst_d   = 1'b0;
    mul_start_d = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    grant_id    = (req0 && req1) ? ptr_q : req1;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d   = S_CLR;
          cnt_d     = '0;
          owner_d   = grant_id;
          ptr_d     = ~grant_id;
          mul_a_d   = grant_id ? a1 : a0;
          mul_b_d   = grant_id ? b1 : b0;
          mul_rst_d = 1'b1;
        end
      end
      S_CLR: begin
        state_d = S_SETUP;
        cnt_d   = SETUP_LOAD;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d     = S_RUN;
          cnt_d       = RUN_LOAD;
          mul_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_CAP;
          cnt_d   = '0;
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          mul_start_d = 1'b1;
        end
      end
      S_CAP: begin
        // Product is sampled here so it is stable on res in the done cycle.
        state_d   = S_DONE;
        cnt_d     = '0;
        res_d     = mul_c;
        res_neg_d = mul_neg;
        done0_d   = ~owner_q;
        done1_d   = owner_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_rst_q   <= 1'b1;
      mul_start_q <= 1'b0;
      res_q       <= '0;
      res_neg_q   <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_rst_q   <= mul_rst_d;
      mul_start_q <= mul_start_d;
      res_q       <= res_d;
      res_neg_q   <= res_neg_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign res       = res_q;
  assign res_neg   = res_neg_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_rst   = mul_rst_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: stand-in multiplier plus a per-cycle timeline model of
// the shared-multiplier service (grant, fixed-length operation, done to the owner).
module tb_mul_share_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int MUL_LAT   = 16;
  localparam int OP_CYC    = SETUP_CYC + MUL_LAT + 4;
  localparam int DONE_PH   = SETUP_CYC + MUL_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        done0, done1, res_neg, busy, mul_rst, mul_start, mul_neg;
  logic [15:0] res, mul_c;
  logic [7:0]  mul_a, mul_b;

  int n_vec = 0;
  int n_err = 0;

  mul_share_ctrl #(.SETUP_CYC(SETUP_CYC), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .res(res), .res_neg(res_neg), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst), .mul_start(mul_start),
    .mul_c(mul_c), .mul_neg(mul_neg)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: product only appears after MUL_LAT cycles of start.
  int ml_cnt = 0;
  int ml_prod;
  always @(posedge clk) begin
    if (mul_rst === 1'b1) ml_cnt <= 0;
    else if (mul_start === 1'b1 && ml_cnt < MUL_LAT) ml_cnt <= ml_cnt + 1;
  end
  always_comb begin
    ml_prod = int'($signed(mul_a)) * int'($signed(mul_b));
    if (ml_cnt == MUL_LAT) begin
      mul_c   = 16'(ml_prod);
      mul_neg = (ml_prod < 0);
    end else begin
      mul_c   = 16'h0BAD;
      mul_neg = 1'b1;
    end
  end

  // Reference model state: phase = cycles since grant (-1 when free).
  int         cyc = 0;
  int         phase = -1;
  bit         ptr = 1'b0;
  bit         own = 1'b0;
  bit         rst_seen = 1'b0;
  logic [7:0] ea = '0, eb = '0;
  int         n_start = 0;
  int         n_mrst = 0;
  int         n_done1 = 0;

  task automatic tick();
    int   p;
    logic g;
    logic [4:0]  exp_ctl;
    logic [16:0] exp_res;
    if (!rst) begin
      phase = -1; ptr = 1'b0; rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (phase >= 0) begin
        phase++;
        if (phase == OP_CYC - 1) phase = -1;
      end else if (req0 || req1) begin
        g     = (req0 && req1) ? ptr : req1;
        own   = g;
        ptr   = ~g;
        ea    = g ? a1 : a0;
        eb    = g ? b1 : b0;
        phase = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_seen) begin
      n_vec++;
      if ({busy, done0, done1, mul_rst, mul_start, res_neg, res, mul_a, mul_b}
          !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0}) begin
        n_err++;
        $display("FAIL reset_vals cyc=%0d got busy=%b d0=%b d1=%b mrst=%b start=%b neg=%b res=%h a=%h b=%h",
                 cyc, busy, done0, done1, mul_rst, mul_start, res_neg, res, mul_a, mul_b);
      end
    end else begin
      exp_ctl = {phase >= 0, phase == 0, phase >= 1 + SETUP_CYC && phase <= SETUP_CYC + MUL_LAT,
                 phase == DONE_PH && !own, phase == DONE_PH && own};
      n_vec++;
      if ({busy, mul_rst, mul_start, done0, done1} !== exp_ctl) begin
        n_err++;
        $display("FAIL ctrl cyc=%0d busy/mrst/start/d0/d1 got=%b exp=%b",
                 cyc, {busy, mul_rst, mul_start, done0, done1}, exp_ctl);
      end
      if (phase >= 0) begin
        n_vec++;
        if ({mul_a, mul_b} !== {ea, eb}) begin
          n_err++;
          $display("FAIL operands cyc=%0d got=%h exp=%h", cyc, {mul_a, mul_b}, {ea, eb});
        end
      end
      if (phase == DONE_PH) begin
        p       = int'($signed(ea)) * int'($signed(eb));
        exp_res = {p < 0, 16'(p)};
        n_vec++;
        if ({res_neg, res} !== exp_res) begin
          n_err++;
          $display("FAIL result cyc=%0d got neg=%b res=%h exp neg=%b res=%h",
                   cyc, res_neg, res, exp_res[16], exp_res[15:0]);
        end
      end
    end
    if (mul_start === 1'b1) n_start++;
    if (mul_rst === 1'b1 && !rst_seen) n_mrst++;
    if (done1 === 1'b1) n_done1++;
  endtask

  function automatic logic sel_done(input int id);
    return (id == 0) ? done0 : (id == 1) ? done1 : (done0 | done1);
  endfunction

  // Advance until the chosen done is seen; a timeout counts as a miscompare.
  task automatic wait_done(input int id, output int at);
    int n;
    n  = 0;
    at = -1;
    while (sel_done(id) !== 1'b1 && n < 3 * OP_CYC) begin
      tick();
      n++;
    end
    n_vec++;
    if (sel_done(id) !== 1'b1) begin
      n_err++;
      $display("FAIL wait_done id=%0d got no done exp done within %0d cycles", id, 3 * OP_CYC);
    end else begin
      at = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    repeat (3) tick();
    n_vec++;
    if ({busy, done0, done1, mul_rst, res} !== {1'b0, 1'b0, 1'b0, 1'b1, 16'h0}) begin
      n_err++;
      $display("FAIL test_reset got busy=%b d0=%b d1=%b mrst=%b res=%h exp 0 0 0 1 0000",
               busy, done0, done1, mul_rst, res);
    end
    req0 = 1'b0; rst = 1'b1;
    tick();
    n_vec++;
    if ({busy, mul_rst} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset got busy=%b mrst=%b exp 0 0", busy, mul_rst);
    end
  endtask

  task automatic test_single_op();
    int t, at;
    req0 = 1'b1; a0 = 8'd2; b0 = 8'hFC;
    n_start = 0; n_mrst = 0; n_done1 = 0;
    t = cyc;
    tick();
    wait_done(0, at);
    n_vec++;
    if (at - t !== 21) begin
      n_err++; $display("FAIL single_latency got %0d exp 21", at - t);
    end
    n_vec++;
    if ({res_neg, res} !== {1'b1, 16'hFFF8}) begin
      n_err++; $display("FAIL single_res got neg=%b res=%h exp neg=1 res=fff8", res_neg, res);
    end
    req0 = 1'b0;
    tick();
    n_vec++;
    if (n_start !== MUL_LAT || n_mrst !== 1 || n_done1 !== 0) begin
      n_err++;
      $display("FAIL single_pulses got start=%0d mrst=%0d done1=%0d exp 16 1 0", n_start, n_mrst, n_done1);
    end
  endtask

  task automatic test_contention();
    int at0, at1;
    rst = 1'b0; tick(); rst = 1'b1;
    req0 = 1'b1; a0 = 8'd9;  b0 = 8'hFD;
    req1 = 1'b1; a1 = 8'hF7; b1 = 8'd3;
    wait_done(0, at0);
    n_vec++;
    if ({done1, res_neg, res} !== {1'b0, 1'b1, 16'hFFE5}) begin
      n_err++; $display("FAIL contend_first got d1=%b neg=%b res=%h exp 0 1 ffe5", done1, res_neg, res);
    end
    req0 = 1'b0;
    wait_done(1, at1);
    n_vec++;
    if (at1 - at0 !== OP_CYC || {res_neg, res} !== {1'b1, 16'hFFE5}) begin
      n_err++;
      $display("FAIL contend_second got gap=%0d neg=%b res=%h exp gap=22 1 ffe5", at1 - at0, res_neg, res);
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int at, prev;
    logic who;
    rst = 1'b0; tick(); rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      wait_done(2, at);
      who = done1;
      n_vec++;
      if (who !== 1'(i % 2) || (i > 0 && at - prev !== OP_CYC)) begin
        n_err++;
        $display("FAIL fairness op=%0d got id=%b gap=%0d exp id=%0d gap=%0d", i, who, at - prev, i % 2, OP_CYC);
      end
      prev = at;
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    tick();
  endtask

  task automatic test_operand_change();
    int t, at;
    req1 = 1'b1; a1 = 8'd5; b1 = 8'd6;
    t = cyc;
    tick();
    tick(); tick();
    a1 = 8'd0; req1 = 1'b0;
    wait_done(1, at);
    n_vec++;
    if (at - t !== 21 || {res_neg, res} !== {1'b0, 16'h001E}) begin
      n_err++;
      $display("FAIL operand_change got lat=%0d neg=%b res=%h exp 21 0 001e", at - t, res_neg, res);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int t, at, n;
    req0 = 1'b1; a0 = 8'hF9; b0 = 8'd11;
    n_start = 0; n = 0;
    tick();
    while (n_start < 8 && n < 40) begin tick(); n++; end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({busy, mul_start, done0, done1} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_run_abort got busy=%b start=%b d0=%b d1=%b exp 0 0 0 0", busy, mul_start, done0, done1);
    end
    rst = 1'b1;
    t = cyc;
    tick();
    wait_done(0, at);
    n_vec++;
    if (at - t !== 21 || {res_neg, res} !== {1'b1, 16'hFFB3}) begin
      n_err++;
      $display("FAIL mid_run_restart got lat=%0d neg=%b res=%h exp 21 1 ffb3", at - t, res_neg, res);
    end
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 79) != 0);
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      tick();
    end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (OP_CYC) tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_fairness();
    test_operand_change();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequencer and 2-way arbiter that shares one Multiplicador instance between two requesters, for example two ALU issue ports. It grants the multiplier round-robin and latches the operands. It then drives the multiplier's clear/start sequence for a fixed compute window, captures the product and sign, and returns them to the winning requester with a one-cycle done pulse. The multiplier has no done output, so completion is timed by counter.

Parameters:
SETUP_CYC, 2, cycles operands are held on mul_a/mul_b before mul_start rises (1..255)
MUL_LAT, 16, cycles mul_start is held high; multiplier result is valid after this (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on next rising clk edge)
req0  in  1  requester 0 wants a multiply; hold until done0
a0  in  8  requester 0 operand A, signed two's complement
b0  in  8  requester 0 operand B, signed
req1  in  1  requester 1 request
a1  in  8  requester 1 operand A
b1  in  8  requester 1 operand B
done0  out  1  one-cycle pulse: result for requester 0 valid on res/res_neg
done1  out  1  one-cycle pulse for requester 1
res  out  16  captured product (mul_c)
res_neg  out  1  captured sign (mul_neg)
busy  out  1  high in every state except IDLE
mul_a  out  8  to Multiplicador A
mul_b  out  8  to Multiplicador B
mul_rst  out  1  to Multiplicador rst (active-high)
mul_start  out  1  to Multiplicador start
mul_c  in  16  from Multiplicador c
mul_neg  in  1  from Multiplicador neg

Behaviour:
- Reset (rst=0): state=IDLE; done0=done1=0; res=0; res_neg=0; busy=0; mul_a=mul_b=0; mul_start=0; mul_rst=1 (multiplier held cleared); RR pointer=0 (requester 0 has priority next); counter=0.
- States: IDLE -> CLR -> SETUP -> RUN -> CAP -> DONE -> IDLE.
- IDLE: mul_rst=0, mul_start=0. If any req is high, grant one, latch its a/b into mul_a/mul_b and its id into an internal owner bit, then go to CLR.
- Arbitration: with one request, grant it. With both, grant the requester the RR pointer names. The pointer flips to the non-granted id on every grant.
- CLR: mul_rst=1 for exactly 1 cycle. Go to SETUP.
- SETUP: mul_rst=0, mul_start=0 for SETUP_CYC cycles. Go to RUN.
- RUN: mul_start=1 for MUL_LAT cycles. Go to CAP.
- CAP: mul_start=0. Register res<=mul_c and res_neg<=mul_neg. Go to DONE.
- DONE: assert done[owner]=1 for this cycle only. Go to IDLE.
- Latency: if the grant is taken in IDLE cycle t, done is high in cycle t+3+SETUP_CYC+MUL_LAT. Defaults: 21 cycles.
- Throughput: one operation per SETUP_CYC+MUL_LAT+4 cycles. There is no overlap.
- Operand stability:
  - Operands are latched at grant. Changes on a/b after grant do not affect the operation.
  - Dropping req after grant does not abort. done is still pulsed.
- Re-request: a requester still holding req in the cycle after its done is treated as a new request, subject to RR. This makes back-to-back from one port with the other idle legal and gives fairness under contention.
- mul_a/mul_b/res/res_neg hold their values between operations. res is valid only in the done cycle; consumers must sample it then.
- Counter is 8 bits and is reloaded on every state entry. Parameter value 0 is illegal.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge with the reset values above.
  - No done pulse is emitted for the aborted op.
  - A requester still holding req re-arbitrates after rst returns high.
- done0 and done1 are never high together. busy=0 only in IDLE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req0=1 -> busy=0, done0=done1=0, mul_rst=1, res=0.
- Single op: req0=1, a0=2, b0=-4 -> mul_rst pulse 1 cycle; mul_start high exactly 16 cycles; done0 pulses at grant+21; res=16'hFFF8, res_neg=1; done1 never asserted.
- Contention: req0=req1=1 in the same cycle after reset; a0=9, b0=-3, a1=-9, b1=3 -> requester 0 served first (res=16'hFFE5, res_neg=1, done0). Requester 1 follows with next grant in the cycle after done0 and identical result on done1.
- Fairness: both reqs held high for 4 ops -> done order 0,1,0,1. Each done is 22 cycles apart (21 from grant plus the IDLE cycle).
- Operand/req change after grant: req1, a1=5, b1=6; after 2 cycles set a1=0 and drop req1 -> res=16'h001E, res_neg=0, done1 still pulses.
- Reset mid-RUN: start op, assert rst=0 at RUN cycle 8 -> next edge is IDLE, mul_start=0, no done. After rst=1 with req held, the op restarts and completes normally.
